// File: rtl/gen_fifo_pkg.sv
// Shared constants and helpers for the generic single-clock FIFO.
// Parameter legality is evaluated here so every user applies the same rules.
package gen_fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int cnt_width(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic bit params_ok(
    input int aw,
    input int pe,
    input int pf,
    input int mode
  );
    int depth;
    depth = 1 << aw;
    return (pe >= 1) && (pe <= depth - 2) &&
           (pf >= 2) && (pf <= depth - 1) &&
           (pf > pe) &&
           (mode == FIFO_MODE_STD || mode == FIFO_MODE_FWFT);
  endfunction

endpackage

// File: rtl/gen_fifo_if.sv
// Write/read/status bundle of the generic FIFO.
// The slave modport is the FIFO side.
interface gen_fifo_if
  import gen_fifo_pkg::*;
#(
  parameter int AW = 9,
  parameter int DW = 512
);

  logic                      clr;
  logic [DW-1:0]             din;
  logic                      wr_en;
  logic                      rd_en;
  logic [DW-1:0]             dout;
  logic                      data_valid;
  logic                      full;
  logic                      empty;
  logic                      prog_full;
  logic                      prog_empty;
  logic [cnt_width(AW)-1:0]  data_count;
  logic                      wr_ack;
  logic                      overflow;
  logic                      underflow;

  modport master (
    output clr, din, wr_en, rd_en,
    input  dout, data_valid, full, empty,
    input  prog_full, prog_empty, data_count,
    input  wr_ack, overflow, underflow
  );

  modport slave (
    input  clr, din, wr_en, rd_en,
    output dout, data_valid, full, empty,
    output prog_full, prog_empty, data_count,
    output wr_ack, overflow, underflow
  );

endinterface

// File: rtl/gen_fifo_ram.sv
// Simple dual-port storage: synchronous write, registered or
// asynchronous read selected by MODE.
module gen_fifo_ram
  import gen_fifo_pkg::*;
#(
  parameter int AW   = 9,
  parameter int DW   = 512,
  parameter int MODE = FIFO_MODE_FWFT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  if (MODE == FIFO_MODE_STD) begin : g_std
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rdata_d;

    always_comb begin
      rdata_d = rdata_q;
      if (re) rdata_d = mem_q[raddr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdata_q <= '0;
      else        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
  end else begin : g_fwft
    // re acts as a show-enable so an empty FIFO presents zero
    logic unused_rst;
    assign unused_rst = rst_n;
    assign rdata = re ? mem_q[raddr] : '0;
  end

endmodule

// File: rtl/gen_sync_fifo.sv
// Generic single-clock FIFO: pointer, count and flag control
// around gen_fifo_ram, with standard or FWFT read mode.
module gen_sync_fifo
  import gen_fifo_pkg::*;
#(
  parameter int P_ADDR_WIDTH       = 9,
  parameter int P_DATA_WIDTH       = 512,
  parameter int P_PROG_EMPT_THRESH = 10,
  parameter int P_PROG_FULL_THRESH = 20,
  parameter int P_READ_MODE        = 1
) (
  input logic       clk,
  input logic       rst_n,
  gen_fifo_if.slave bus
);

  localparam int AW = P_ADDR_WIDTH;
  localparam int CW = cnt_width(AW);
  localparam logic [CW-1:0] DEPTH = CW'(1 << AW);
  localparam logic [CW-1:0] PE_TH = CW'(P_PROG_EMPT_THRESH);
  localparam logic [CW-1:0] PF_TH = CW'(P_PROG_FULL_THRESH);
  localparam bit STD = (P_READ_MODE == FIFO_MODE_STD);

  if (!params_ok(AW, P_PROG_EMPT_THRESH,
                 P_PROG_FULL_THRESH, P_READ_MODE)) begin : g_chk
    $fatal(1, "gen_sync_fifo: illegal parameter set");
  end

  logic          wr_go, rd_go, ram_re;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          pfull_q, pfull_d;
  logic          pempty_q, pempty_d;
  logic          wr_ack_q, wr_ack_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          dv_q, dv_d;

  // Acceptance uses only registered flags: no request-to-flag path
  always_comb begin
    wr_go    = bus.wr_en & ~full_q & ~bus.clr;
    rd_go    = bus.rd_en & ~empty_q & ~bus.clr;
    count_d  = count_q + CW'(wr_go) - CW'(rd_go);
    wr_ptr_d = wr_ptr_q + AW'(wr_go);
    rd_ptr_d = rd_ptr_q + AW'(rd_go);
    if (bus.clr) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
    full_d   = (count_d == DEPTH);
    empty_d  = (count_d == '0);
    pfull_d  = (count_d >= PF_TH);
    pempty_d = (count_d <= PE_TH);
    wr_ack_d = wr_go;
    ovf_d    = bus.wr_en & full_q & ~bus.clr;
    udf_d    = bus.rd_en & empty_q & ~bus.clr;
    dv_d     = STD & rd_go;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      pfull_q  <= 1'b0;
      pempty_q <= 1'b1;
      wr_ack_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      dv_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      pfull_q  <= pfull_d;
      pempty_q <= pempty_d;
      wr_ack_q <= wr_ack_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      dv_q     <= dv_d;
    end
  end

  assign ram_re = STD ? rd_go : ~empty_q;

  gen_fifo_ram #(
    .AW   (AW),
    .DW   (P_DATA_WIDTH),
    .MODE (P_READ_MODE)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_go),
    .waddr (wr_ptr_q),
    .wdata (bus.din),
    .re    (ram_re),
    .raddr (rd_ptr_q),
    .rdata (bus.dout)
  );

  assign bus.data_valid = STD ? dv_q : ~empty_q;
  assign bus.full       = full_q;
  assign bus.empty      = empty_q;
  assign bus.prog_full  = pfull_q;
  assign bus.prog_empty = pempty_q;
  assign bus.data_count = count_q;
  assign bus.wr_ack     = wr_ack_q;
  assign bus.overflow   = ovf_q;
  assign bus.underflow  = udf_q;

endmodule

// File: tb/tb_gen_sync_fifo.sv
// Directed bench: standard and FWFT instances, depth 16,
// thresholds 3/12, driven with identical stimulus.
module tb_gen_sync_fifo;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [15:0] q[$];
  logic [15:0] exp_d;
  logic [15:0] d;

  always #5 clk = ~clk;

  gen_fifo_if #(.AW(4), .DW(16)) if_s ();
  gen_fifo_if #(.AW(4), .DW(16)) if_f ();

  gen_sync_fifo #(
    .P_ADDR_WIDTH(4), .P_DATA_WIDTH(16),
    .P_PROG_EMPT_THRESH(3), .P_PROG_FULL_THRESH(12),
    .P_READ_MODE(0)
  ) u_std (.clk(clk), .rst_n(rst_n), .bus(if_s));

  gen_sync_fifo #(
    .P_ADDR_WIDTH(4), .P_DATA_WIDTH(16),
    .P_PROG_EMPT_THRESH(3), .P_PROG_FULL_THRESH(12),
    .P_READ_MODE(1)
  ) u_fwft (.clk(clk), .rst_n(rst_n), .bus(if_f));

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic w, input logic r,
                       input logic c, input logic [15:0] dd);
    if_s.wr_en = w; if_s.rd_en = r; if_s.clr = c; if_s.din = dd;
    if_f.wr_en = w; if_f.rd_en = r; if_f.clr = c; if_f.din = dd;
  endtask

  task automatic step(input logic w, input logic r,
                      input logic c, input logic [15:0] dd);
    @(negedge clk);
    drive(w, r, c, dd);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    #12;
    chk("rst_empty",  32'(if_s.empty), 32'd1);
    chk("rst_pempty", 32'(if_f.prog_empty), 32'd1);
    chk("rst_full",   32'(if_s.full), 32'd0);
    chk("rst_pfull",  32'(if_f.prog_full), 32'd0);
    chk("rst_cnt",    32'(if_s.data_count), 32'd0);
    chk("rst_dout_s", 32'(if_s.dout), 32'd0);
    chk("rst_dout_f", 32'(if_f.dout), 32'd0);
    chk("rst_dv_s",   32'(if_s.data_valid), 32'd0);
    chk("rst_dv_f",   32'(if_f.data_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0, 1'b0, 16'(i));
      chk("fill_cnt",    32'(if_s.data_count), 32'(i));
      chk("fill_pfull",  32'(if_f.prog_full), 32'(i >= 12));
      chk("fill_pempty", 32'(if_s.prog_empty), 32'(i <= 3));
    end
    chk("fill_full_s", 32'(if_s.full), 32'd1);
    chk("fill_full_f", 32'(if_f.full), 32'd1);
    chk("fill_ack",    32'(if_s.wr_ack), 32'd1);
    chk("fill_dout_f", 32'(if_f.dout), 32'h1);
    chk("fill_dv_f",   32'(if_f.data_valid), 32'd1);
    chk("fill_dv_s",   32'(if_s.data_valid), 32'd0);

    step(1'b1, 1'b0, 1'b0, 16'd17);
    chk("ovf_pulse", 32'(if_s.overflow), 32'd1);
    chk("ovf_ack",   32'(if_s.wr_ack), 32'd0);
    chk("ovf_cnt",   32'(if_f.data_count), 32'd16);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    chk("ovf_clear", 32'(if_s.overflow), 32'd0);

    step(1'b1, 1'b1, 1'b0, 16'h11);
    chk("fullrw_ovf",    32'(if_f.overflow), 32'd1);
    chk("fullrw_cnt",    32'(if_s.data_count), 32'd15);
    chk("fullrw_full",   32'(if_s.full), 32'd0);
    chk("fullrw_dout_s", 32'(if_s.dout), 32'h1);
    chk("fullrw_dv_s",   32'(if_s.data_valid), 32'd1);
    chk("fullrw_dout_f", 32'(if_f.dout), 32'h2);

    for (int i = 2; i <= 16; i++) begin
      chk("drain_dout_f", 32'(if_f.dout), 32'(i));
      step(1'b0, 1'b1, 1'b0, 16'h0);
      chk("drain_dout_s", 32'(if_s.dout), 32'(i));
      chk("drain_dv_s",   32'(if_s.data_valid), 32'd1);
    end
    chk("drain_empty", 32'(if_s.empty), 32'd1);
    chk("drain_cnt",   32'(if_f.data_count), 32'd0);
    chk("drain_dv_f",  32'(if_f.data_valid), 32'd0);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    chk("idle_dv_s", 32'(if_s.data_valid), 32'd0);

    step(1'b0, 1'b1, 1'b0, 16'h0);
    chk("udf_s",      32'(if_s.underflow), 32'd1);
    chk("udf_f",      32'(if_f.underflow), 32'd1);
    chk("udf_cnt",    32'(if_s.data_count), 32'd0);
    chk("udf_dout_s", 32'(if_s.dout), 32'h10);
    chk("udf_dv_s",   32'(if_s.data_valid), 32'd0);
    chk("udf_dv_f",   32'(if_f.data_valid), 32'd0);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    chk("udf_clear", 32'(if_f.underflow), 32'd0);

    step(1'b1, 1'b1, 1'b0, 16'h20);
    chk("emprw_udf",    32'(if_s.underflow), 32'd1);
    chk("emprw_ack",    32'(if_s.wr_ack), 32'd1);
    chk("emprw_cnt",    32'(if_f.data_count), 32'd1);
    chk("emprw_dout_f", 32'(if_f.dout), 32'h20);
    chk("emprw_dout_s", 32'(if_s.dout), 32'h10);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    chk("emprw_pop_cnt", 32'(if_s.data_count), 32'd0);
    chk("emprw_pop_s",   32'(if_s.dout), 32'h20);

    step(1'b1, 1'b0, 1'b0, 16'hA5);
    chk("fwft_empty",  32'(if_f.empty), 32'd0);
    chk("fwft_dout",   32'(if_f.dout), 32'hA5);
    chk("fwft_dv",     32'(if_f.data_valid), 32'd1);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    chk("fwft_pop_empty",  32'(if_f.empty), 32'd1);
    chk("fwft_pop_pempty", 32'(if_f.prog_empty), 32'd1);
    chk("fwft_pop_dv",     32'(if_f.data_valid), 32'd0);
    chk("std_pop_dout",    32'(if_s.dout), 32'hA5);

    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 1'b0, 16'(i));
    chk("std_wr_dv", 32'(if_s.data_valid), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0);
      chk("std_rd_dout", 32'(if_s.dout), 32'(i));
      chk("std_rd_dv",   32'(if_s.data_valid), 32'd1);
    end
    step(1'b0, 1'b0, 1'b0, 16'h0);
    chk("std_after_dv", 32'(if_s.data_valid), 32'd0);

    for (int i = 1; i <= 10; i++) step(1'b1, 1'b0, 1'b0, 16'(16'h40 + i));
    chk("pre_clr_cnt", 32'(if_s.data_count), 32'd10);
    step(1'b1, 1'b0, 1'b1, 16'h99);
    chk("clr_cnt",    32'(if_s.data_count), 32'd0);
    chk("clr_empty",  32'(if_f.empty), 32'd1);
    chk("clr_pempty", 32'(if_s.prog_empty), 32'd1);
    chk("clr_ack",    32'(if_s.wr_ack), 32'd0);
    chk("clr_ovf",    32'(if_f.overflow), 32'd0);
    chk("clr_dv_s",   32'(if_s.data_valid), 32'd0);
    chk("clr_dv_f",   32'(if_f.data_valid), 32'd0);
    chk("clr_dout_s", 32'(if_s.dout), 32'h4);

    q.delete();
    step(1'b1, 1'b0, 1'b0, 16'h100);
    q.push_back(16'h100);
    step(1'b1, 1'b0, 1'b0, 16'h101);
    q.push_back(16'h101);
    for (int i = 2; i < 40; i++) begin
      d = 16'(16'h100 + i);
      chk("wrap_dout_f", 32'(if_f.dout), 32'(q[0]));
      step(1'b1, 1'b1, 1'b0, d);
      exp_d = q.pop_front();
      q.push_back(d);
      chk("wrap_dout_s", 32'(if_s.dout), 32'(exp_d));
      chk("wrap_cnt",    32'(if_s.data_count), 32'd2);
      chk("wrap_empty",  32'(if_f.empty), 32'd0);
      chk("wrap_full",   32'(if_s.full), 32'd0);
    end
    for (int k = 0; k < 2; k++) begin
      chk("wdrain_dout_f", 32'(if_f.dout), 32'(q[0]));
      step(1'b0, 1'b1, 1'b0, 16'h0);
      exp_d = q.pop_front();
      chk("wdrain_dout_s", 32'(if_s.dout), 32'(exp_d));
    end
    chk("wdrain_empty", 32'(if_s.empty), 32'd1);

    for (int i = 1; i <= 6; i++) step(1'b1, 1'b0, 1'b0, 16'(16'h70 + i));
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 16'h77);
    @(posedge clk);
    #1;
    chk("mid_cnt", 32'(if_s.data_count), 32'd7);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_empty",  32'(if_s.empty), 32'd1);
    chk("arst_full",   32'(if_f.full), 32'd0);
    chk("arst_cnt",    32'(if_s.data_count), 32'd0);
    chk("arst_pempty", 32'(if_f.prog_empty), 32'd1);
    chk("arst_pfull",  32'(if_s.prog_full), 32'd0);
    chk("arst_dout_s", 32'(if_s.dout), 32'd0);
    chk("arst_dv_f",   32'(if_f.data_valid), 32'd0);
    chk("arst_ack",    32'(if_s.wr_ack), 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 16'h0);
    chk("post_ack", 32'(if_s.wr_ack), 32'd0);
    chk("post_ovf", 32'(if_f.overflow), 32'd0);
    chk("post_cnt", 32'(if_f.data_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
